// File: rtl/hist_sram_ctrl_pkg.sv
// Shared types and constants for the histogram SRAM controller.
// Holds the FSM state encoding, the grant encoding and the default access timing.
package hist_sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ACT,
    ST_RD_DONE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_t;

  typedef enum logic [1:0] {
    GNT_INC,
    GNT_RD,
    GNT_CLR
  } gnt_t;

  localparam int T_RD_DEF = 2;
  localparam int T_WE_DEF = 2;

  localparam logic [15:0] DW_MAX = 16'hFFFF;

endpackage

// File: rtl/hist_sram_ctrl_if.sv
// Bundle of the requester handshakes and the SRAM-side pins of the histogram controller.
// slave = the controller itself, master = the surrounding logic and the SRAM/pad side.
interface hist_sram_ctrl_if #(
  parameter int AW = 20,
  parameter int DW = 16
);

  logic          inc_req;
  logic [AW-1:0] inc_addr;
  logic          inc_ack;

  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;

  logic          sat_flag;
  logic          busy;

  logic [AW-1:0] sram_adr;
  logic          sram_oen;
  logic          sram_wen;
  logic [DW-1:0] dq_out;
  logic          dq_oe;
  logic [DW-1:0] dq_in;

  modport slave (
    input  inc_req, inc_addr, rd_req, rd_addr, clr_start, dq_in,
    output inc_ack, rd_data, rd_valid, clr_busy, clr_done, sat_flag, busy,
    output sram_adr, sram_oen, sram_wen, dq_out, dq_oe
  );

  modport master (
    output inc_req, inc_addr, rd_req, rd_addr, clr_start, dq_in,
    input  inc_ack, rd_data, rd_valid, clr_busy, clr_done, sat_flag, busy,
    input  sram_adr, sram_oen, sram_wen, dq_out, dq_oe
  );

endinterface

// File: rtl/hist_sram_ctrl.sv
// Sequencer for the external async histogram SRAM: increment RMW, readout and clear sweep.
// All SRAM pins are driven from registers; the DQ tri-state lives at top level.
module hist_sram_ctrl
  import hist_sram_ctrl_pkg::*;
#(
  parameter int AW    = 20,
  parameter int DW    = 16,
  parameter int NBINS = 1024,
  parameter int T_RD  = T_RD_DEF,
  parameter int T_WE  = T_WE_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  hist_sram_ctrl_if.slave bus
);

  localparam logic [AW:0]   LP_NBINS = (AW+1)'(NBINS);
  localparam logic [AW-1:0] LP_LAST  = AW'(NBINS - 1);
  localparam logic [7:0]    LP_TRD   = 8'(T_RD - 1);
  localparam logic [7:0]    LP_TWE   = 8'(T_WE - 1);

  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
    return (v == {DW{1'b1}}) ? v : v + DW'(1);
  endfunction

  state_t        r_state;
  gnt_t          r_gnt;
  logic [7:0]    r_phase;
  logic [AW-1:0] r_clr_addr;
  logic [AW-1:0] r_adr;
  logic          r_oen;
  logic          r_wen;
  logic          r_dq_oe;
  logic [DW-1:0] r_dq_out;
  logic [DW-1:0] r_rd_data;
  logic          r_inc_ack;
  logic          r_rd_valid;
  logic          r_clr_busy;
  logic          r_clr_done;
  logic          r_sat;
  logic          r_last_inc;

  logic w_inc_oor;
  logic w_pick_inc;
  logic w_pick_rd;
  logic w_arb;
  logic w_oor_ack;

  // Round-robin: on a tie the requester not served last wins.
  assign w_inc_oor  = {1'b0, bus.inc_addr} >= LP_NBINS;
  assign w_pick_inc = bus.inc_req && (!bus.rd_req || !r_last_inc);
  assign w_pick_rd  = bus.rd_req && !w_pick_inc;
  assign w_arb      = (r_state == ST_IDLE) && !r_clr_busy;
  assign w_oor_ack  = w_arb && w_pick_inc && w_inc_oor;

  assign bus.inc_ack  = r_inc_ack | w_oor_ack;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.clr_busy = r_clr_busy;
  assign bus.clr_done = r_clr_done;
  assign bus.sat_flag = r_sat;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.sram_adr = r_adr;
  assign bus.sram_oen = r_oen;
  assign bus.sram_wen = r_wen;
  assign bus.dq_out   = r_dq_out;
  assign bus.dq_oe    = r_dq_oe;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_gnt      <= GNT_INC;
      r_phase    <= '0;
      r_clr_addr <= '0;
      r_adr      <= '0;
      r_oen      <= 1'b1;
      r_wen      <= 1'b1;
      r_dq_oe    <= 1'b0;
      r_dq_out   <= '0;
      r_rd_data  <= '0;
      r_inc_ack  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
      r_sat      <= 1'b0;
      r_last_inc <= 1'b0;
    end else begin
      r_inc_ack  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_clr_done <= 1'b0;

      if (bus.clr_start && !r_clr_busy) begin
        r_clr_busy <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_clr_busy) begin
            r_gnt      <= GNT_CLR;
            r_sat      <= 1'b0;
            r_clr_addr <= '0;
            r_adr      <= '0;
            r_dq_out   <= '0;
            r_dq_oe    <= 1'b1;
            r_state    <= ST_WR_SETUP;
          end else if (w_pick_inc) begin
            r_last_inc <= 1'b1;
            if (!w_inc_oor) begin
              r_gnt   <= GNT_INC;
              r_adr   <= bus.inc_addr;
              r_oen   <= 1'b0;
              r_phase <= LP_TRD;
              r_state <= ST_RD_ACT;
            end
          end else if (w_pick_rd) begin
            r_last_inc <= 1'b0;
            r_gnt      <= GNT_RD;
            r_adr      <= bus.rd_addr;
            r_oen      <= 1'b0;
            r_phase    <= LP_TRD;
            r_state    <= ST_RD_ACT;
          end
        end

        ST_RD_ACT: begin
          if (r_phase != 8'd0) begin
            r_phase <= r_phase - 8'd1;
          end else begin
            r_oen <= 1'b1;
            if (r_gnt == GNT_RD) begin
              r_rd_data  <= bus.dq_in;
              r_rd_valid <= 1'b1;
              r_state    <= ST_RD_DONE;
            end else begin
              r_dq_out <= sat_inc(bus.dq_in);
              if (bus.dq_in == {DW{1'b1}}) begin
                r_sat <= 1'b1;
              end
              r_state <= ST_WR_SETUP;
            end
          end
        end

        ST_RD_DONE: begin
          r_state <= ST_IDLE;
        end

        // Coming from a read, DQ_OE waits one cycle after OEN rises so the SRAM releases the bus first.
        ST_WR_SETUP: begin
          if (!r_dq_oe) begin
            r_dq_oe <= 1'b1;
          end else begin
            r_wen   <= 1'b0;
            r_phase <= LP_TWE;
            r_state <= ST_WR_PULSE;
          end
        end

        ST_WR_PULSE: begin
          if (r_phase != 8'd0) begin
            r_phase <= r_phase - 8'd1;
          end else begin
            r_wen   <= 1'b1;
            r_state <= ST_WR_HOLD;
            if (r_gnt == GNT_INC) begin
              r_inc_ack <= 1'b1;
            end
          end
        end

        // Between clear bins DQ stays driven; OEN is held high for the whole sweep.
        ST_WR_HOLD: begin
          if ((r_gnt == GNT_CLR) && (r_clr_addr != LP_LAST)) begin
            r_clr_addr <= r_clr_addr + AW'(1);
            r_adr      <= r_clr_addr + AW'(1);
            r_state    <= ST_WR_SETUP;
          end else begin
            r_dq_oe <= 1'b0;
            r_state <= ST_IDLE;
            if (r_gnt == GNT_CLR) begin
              r_clr_busy <= 1'b0;
              r_clr_done <= 1'b1;
              r_clr_addr <= '0;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hist_sram_ctrl.sv
// Directed bench for hist_sram_ctrl with a behavioural async SRAM model and bus-protocol monitors.
module tb_hist_sram_ctrl;
  import hist_sram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  hist_sram_ctrl_if #(.AW(20), .DW(16)) bus();

  hist_sram_ctrl #(
    .AW(20), .DW(16), .NBINS(1024), .T_RD(2), .T_WE(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  // SRAM model: read data only while OEN is low, write while WEN is low with DQ driven
  logic [15:0] mem [0:2047];
  logic        pre_we = 1'b0;
  logic [10:0] pre_a  = '0;
  logic [15:0] pre_d  = '0;

  assign bus.dq_in = bus.sram_oen ? 16'hDEAD : mem[bus.sram_adr[10:0]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (!bus.sram_wen && bus.dq_oe) mem[bus.sram_adr[10:0]] <= bus.dq_out;
  end

  int ovl_err = 0, sep_err = 0, act_cnt = 0, zw_cnt = 0, done_cnt = 0;
  logic prev_oen_n = 1'b0, prev_dq_oe = 1'b0, prev_wen_n = 1'b0;

  always @(negedge clk) begin
    if (!bus.sram_oen && !bus.sram_wen) ovl_err <= ovl_err + 1;
    if (bus.dq_oe && (!bus.sram_oen || prev_oen_n)) sep_err <= sep_err + 1;
    if (!bus.sram_oen && prev_dq_oe) sep_err <= sep_err + 1;
    if (!bus.sram_oen || !bus.sram_wen) act_cnt <= act_cnt + 1;
    if (prev_wen_n && bus.sram_wen && (bus.dq_out == 16'h0000)) zw_cnt <= zw_cnt + 1;
    if (bus.clr_done) done_cnt <= done_cnt + 1;
    prev_oen_n <= !bus.sram_oen;
    prev_dq_oe <= bus.dq_oe;
    prev_wen_n <= !bus.sram_wen;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [10:0] a, input logic [15:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  // Ticks until the selected pulse is seen; n = ticks taken, -1 on timeout
  task automatic wait_sig(input int which, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if ((which == 0 && bus.inc_ack) || (which == 1 && bus.rd_valid) ||
          (which == 2 && bus.clr_done)) begin
        n = i;
        break;
      end
    end
  endtask

  int n, ops, ninc, nrd, act0, zw0, done0, rd_early, busy_drop, sat_bad;
  logic [3:0] ord;

  initial begin
    bus.inc_req = 1'b0; bus.inc_addr = '0;
    bus.rd_req = 1'b0;  bus.rd_addr = '0;
    bus.clr_start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_oen", bus.sram_oen, 1);
    chk("rst_wen", bus.sram_wen, 1);
    chk("rst_dq_oe", bus.dq_oe, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_clr_busy", bus.clr_busy, 0);
    chk("rst_sat", bus.sat_flag, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_adr", bus.sram_adr, 0);

    preload(11'd5, 16'h0003);
    preload(11'd9, DW_MAX);
    preload(11'd20, 16'h1234);
    preload(11'd21, 16'h0042);
    preload(11'd30, 16'h0010);
    preload(11'd40, 16'h0007);

    // Round-robin with both requesters held: INC, RD, INC, RD
    bus.inc_addr = 20'd30; bus.rd_addr = 20'd20;
    bus.inc_req = 1'b1; bus.rd_req = 1'b1;
    ord = '0; ops = 0; ninc = 0; nrd = 0;
    for (int i = 0; i < 200 && ops < 4; i++) begin
      tick();
      if (bus.inc_ack) begin
        ord = {ord[2:0], 1'b0}; ops++; ninc++;
        if (ninc == 2) bus.inc_req = 1'b0;
      end
      if (bus.rd_valid) begin
        ord = {ord[2:0], 1'b1}; ops++; nrd++;
        chk("rr_rd_data", bus.rd_data, 16'h1234);
        if (nrd == 2) bus.rd_req = 1'b0;
      end
    end
    chk("rr_ops", ops, 4);
    chk("rr_order", ord, 4'b0101);
    tick();
    chk("rr_mem30", mem[30], 16'h0012);

    // Single readout latency and hold of RD_DATA
    bus.rd_addr = 20'd21; bus.rd_req = 1'b1;
    wait_sig(1, 20, n);
    bus.rd_req = 1'b0;
    chk("rd_latency", n, 3);
    chk("rd_data", bus.rd_data, 16'h0042);
    tick(); tick();
    chk("rd_data_held", bus.rd_data, 16'h0042);
    chk("rd_valid_pulse", bus.rd_valid, 0);

    // Increment bin 5: 3 -> 4, ack 7 cycles after the grant cycle
    bus.inc_addr = 20'd5; bus.inc_req = 1'b1;
    wait_sig(0, 20, n);
    bus.inc_req = 1'b0;
    chk("inc_latency", n, 7);
    chk("inc_mem5", mem[5], 16'h0004);
    chk("inc_no_sat", bus.sat_flag, 0);
    tick();
    chk("inc_ack_pulse", bus.inc_ack, 0);

    // Saturating increment of bin 9
    bus.inc_addr = 20'd9; bus.inc_req = 1'b1;
    wait_sig(0, 20, n);
    bus.inc_req = 1'b0;
    chk("sat_latency", n, 7);
    chk("sat_mem9", mem[9], DW_MAX);
    chk("sat_flag", bus.sat_flag, 1);
    tick();

    // Out-of-range increment: acked in the IDLE cycle, no SRAM strobes
    act0 = act_cnt;
    bus.inc_addr = 20'd2000; bus.inc_req = 1'b1;
    #1;
    chk("oor_ack", bus.inc_ack, 1);
    tick();
    bus.inc_req = 1'b0;
    tick(); tick();
    chk("oor_no_access", act_cnt - act0, 0);
    chk("oor_busy", bus.busy, 0);

    // Clear requested during an in-flight increment, readout held off
    zw0 = zw_cnt; done0 = done_cnt;
    bus.inc_addr = 20'd5; bus.inc_req = 1'b1;
    tick(); tick();
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    bus.rd_addr = 20'd21; bus.rd_req = 1'b1;
    chk("clr_busy_latched", bus.clr_busy, 1);
    wait_sig(0, 20, n);
    bus.inc_req = 1'b0;
    chk("clr_inflight_ack", n, 4);
    chk("clr_inflight_mem5", mem[5], 16'h0005);
    chk("clr_sat_before", bus.sat_flag, 1);
    n = -1; rd_early = 0; busy_drop = 0; sat_bad = 0;
    for (int i = 1; i <= 6000; i++) begin
      bus.clr_start = (i == 100);
      tick();
      if (bus.rd_valid) rd_early++;
      if (bus.clr_done) begin
        n = i;
        break;
      end
      if (!bus.clr_busy) busy_drop++;
      if (i > 2 && bus.sat_flag) sat_bad++;
    end
    bus.clr_start = 1'b0;
    chk("clr_sweep_len", n, 4098);
    chk("clr_rd_held_off", rd_early, 0);
    chk("clr_busy_through", busy_drop, 0);
    chk("clr_sat_cleared", sat_bad, 0);
    chk("clr_busy_fall", bus.clr_busy, 0);
    wait_sig(1, 20, n);
    bus.rd_req = 1'b0;
    chk("clr_rd_after", n, 3);
    chk("clr_rd_zero", bus.rd_data, 0);
    repeat (10) tick();
    chk("clr_zero_writes", zw_cnt - zw0, 1024);
    chk("clr_done_once", done_cnt - done0, 1);
    chk("clr_restart_ignored", bus.clr_busy, 0);
    chk("clr_mem1023", mem[1023], 0);
    chk("clr_mem9", mem[9], 0);

    // Reset in the middle of a write pulse, then a fresh increment
    preload(11'd40, 16'h0007);
    bus.inc_addr = 20'd40; bus.inc_req = 1'b1;
    repeat (5) tick();
    chk("rstw_in_pulse", bus.sram_wen, 0);
    rst = 1'b1;
    #1;
    chk("rstw_wen", bus.sram_wen, 1);
    chk("rstw_oen", bus.sram_oen, 1);
    chk("rstw_dq_oe", bus.dq_oe, 0);
    chk("rstw_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    wait_sig(0, 20, n);
    bus.inc_req = 1'b0;
    chk("rstw_inc_latency", n, 7);
    chk("rstw_mem40", mem[40], 16'h0008);
    tick();

    chk("no_oen_wen_overlap", ovl_err, 0);
    chk("dq_oen_separation", sep_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
